sonar_frame_rx: RTL and testbench

Host-side serial receiver and frame parser placed directly downstream of the sonar's saida_serial output. It deserialises 7-bit ASCII characters and parses the sonar report frame "AAA,DDDD#", where AAA is the angle in ASCII decimal and DDDD is the distance in ASCII decimal. On each complete, well-formed frame it latches BCD angle and distance and pulses frame_valid. It feeds the host display/logging logic and the debug hexa7seg path.

---
 rtl/sonar_frame_rx_if.sv | 33 +++
 rtl/sonar_frame_rx.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_sonar_frame_rx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sonar_frame_rx_if.sv
// Bus between the sonar host receiver and its consumer: the serial line in,
// plus the parsed BCD report, the status strobes and the debug state codes.
// slave  = receiver side (sonar_frame_rx), master = host/driver side.
`timescale 1ns/1ps
interface sonar_frame_rx_if;
    logic        rx_serial;
    logic [11:0] angle_bcd;
    logic [15:0] distance_bcd;
    logic        frame_valid;
    logic        frame_error;
    logic [3:0]  db_rx_state;
    logic [3:0]  db_parser_state;

    modport slave (
        input  rx_serial,
        output angle_bcd,
        output distance_bcd,
        output frame_valid,
        output frame_error,
        output db_rx_state,
        output db_parser_state
    );

    modport master (
        output rx_serial,
        input  angle_bcd,
        input  distance_bcd,
        input  frame_valid,
        input  frame_error,
        input  db_rx_state,
        input  db_parser_state
    );
endinterface

// File: rtl/sonar_frame_rx.sv
// Host-side receiver for the sonar report stream "AAA,DDDD#".
// Deserialises 7E1 characters (start, 7 data LSB first, even parity, stop),
// parses the frame and latches BCD angle/distance on each good frame.
// Optional build macro SONAR_RX_PARITY_EN: when defined the parity bit is
// checked and a mismatch is treated like a framing error; otherwise the
// parity bit slot is skipped.
`timescale 1ns/1ps
module sonar_frame_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic            clock,
    input  logic            reset,
    sonar_frame_rx_if.slave bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_DONE   = 3'd5
    } rx_state_t;

    typedef enum logic [2:0] {
        PS_ANG   = 3'd0,
        PS_COMMA = 3'd1,
        PS_DIST  = 3'd2,
        PS_END   = 3'd3,
        PS_SYNC  = 3'd4
    } ps_state_t;

    // ---------------- serial line synchroniser ----------------
    logic sync1_q, sync2_q, prev_q;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection;
    // preset to the idle-high level so reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= bus.rx_serial;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // ---------------- character receiver ----------------
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [6:0]       data_q;
    logic             stop_q;
    logic             bit_tick;
    logic             parity_ok;
    logic             char_strobe;
    logic             rx_err;

    // Bit timing: every sample point after the start check is a whole bit
    // period later, which puts all samples at mid-bit.
    assign bit_tick = (cnt_q == FULL_LAST);

    // Receiver state, bit-period counter and data-bit index.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
        end
    end

    // Receiver next-state: a start-bit check at half period filters glitches.
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (prev_q && !sync2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d      = '0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd6) rx_state_d = RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (bit_tick) begin
                    cnt_d      = '0;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (bit_tick) begin
                    cnt_d      = '0;
                    rx_state_d = RX_DONE;
                end
            end
            RX_DONE: begin
                cnt_d      = '0;
                rx_state_d = RX_IDLE;
            end
            default: begin
                cnt_d      = '0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // Sampled character bits; pure data, only meaningful once DONE is reached.
    always_ff @(posedge clock) begin
        if (rx_state_q == RX_DATA && bit_tick) data_q <= {sync2_q, data_q[6:1]};
        if (rx_state_q == RX_STOP && bit_tick) stop_q <= sync2_q;
    end

`ifdef SONAR_RX_PARITY_EN
    logic par_q;

    // Parity bit capture for the even-parity check.
    always_ff @(posedge clock) begin
        if (rx_state_q == RX_PARITY && bit_tick) par_q <= sync2_q;
    end

    assign parity_ok = (par_q == ^data_q);
`else
    assign parity_ok = 1'b1;
`endif

    assign char_strobe = (rx_state_q == RX_DONE) &&  (stop_q && parity_ok);
    assign rx_err      = (rx_state_q == RX_DONE) && !(stop_q && parity_ok);

    // ---------------- frame parser ----------------
    ps_state_t   ps_q, ps_d;
    logic [1:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic        perr_q, perr_d;
    logic        load_ang, load_dist;
    logic        is_digit;
    logic [11:0] ang_sh_q, angle_q;
    logic [15:0] dist_sh_q, dist_q;

    assign is_digit = (data_q[6:4] == 3'b011) && (data_q[3:0] <= 4'd9);

    // Parser next-state: digits fill the shadow MSD first; anything unexpected
    // drops to SYNC, which waits for the next '#' to realign.
    always_comb begin
        ps_d      = ps_q;
        idx_d     = idx_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        load_ang  = 1'b0;
        load_dist = 1'b0;
        if (rx_err) begin
            ps_d  = PS_SYNC;
            idx_d = '0;
        end else if (char_strobe) begin
            case (ps_q)
                PS_ANG: begin
                    if (is_digit) begin
                        load_ang = 1'b1;
                        if (idx_q == 2'd2) begin
                            ps_d  = PS_COMMA;
                            idx_d = '0;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        perr_d = 1'b1;
                        ps_d   = PS_SYNC;
                        idx_d  = '0;
                    end
                end
                PS_COMMA: begin
                    if (data_q == 7'h2C) begin
                        ps_d = PS_DIST;
                    end else begin
                        perr_d = 1'b1;
                        ps_d   = PS_SYNC;
                    end
                    idx_d = '0;
                end
                PS_DIST: begin
                    if (is_digit) begin
                        load_dist = 1'b1;
                        if (idx_q == 2'd3) begin
                            ps_d  = PS_END;
                            idx_d = '0;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        perr_d = 1'b1;
                        ps_d   = PS_SYNC;
                        idx_d  = '0;
                    end
                end
                PS_END: begin
                    if (data_q == 7'h23) begin
                        valid_d = 1'b1;
                        ps_d    = PS_ANG;
                    end else begin
                        perr_d = 1'b1;
                        ps_d   = PS_SYNC;
                    end
                    idx_d = '0;
                end
                PS_SYNC: begin
                    if (data_q == 7'h23) ps_d = PS_ANG;
                    idx_d = '0;
                end
                default: begin
                    ps_d  = PS_SYNC;
                    idx_d = '0;
                end
            endcase
        end
    end

    // Parser state, status strobes and the committed output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ps_q    <= PS_ANG;
            idx_q   <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            angle_q <= '0;
            dist_q  <= '0;
        end else begin
            ps_q    <= ps_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            if (valid_d) begin
                angle_q <= ang_sh_q;
                dist_q  <= dist_sh_q;
            end
        end
    end

    // Shadow digits; a new frame rewrites every digit before it can commit.
    always_ff @(posedge clock) begin
        if (load_ang) begin
            case (idx_q)
                2'd0:    ang_sh_q[11:8] <= data_q[3:0];
                2'd1:    ang_sh_q[7:4]  <= data_q[3:0];
                default: ang_sh_q[3:0]  <= data_q[3:0];
            endcase
        end
        if (load_dist) begin
            case (idx_q)
                2'd0:    dist_sh_q[15:12] <= data_q[3:0];
                2'd1:    dist_sh_q[11:8]  <= data_q[3:0];
                2'd2:    dist_sh_q[7:4]   <= data_q[3:0];
                default: dist_sh_q[3:0]   <= data_q[3:0];
            endcase
        end
    end

    // Receiver errors fire in DONE, parser errors one cycle after a strobe,
    // so the two sources and frame_valid can never coincide.
    assign bus.angle_bcd       = angle_q;
    assign bus.distance_bcd    = dist_q;
    assign bus.frame_valid     = valid_q;
    assign bus.frame_error     = rx_err | perr_q;
    assign bus.db_rx_state     = {1'b0, rx_state_q};
    assign bus.db_parser_state = {1'b0, ps_q};

endmodule

// File: tb/tb_sonar_frame_rx.sv
// Directed bench for sonar_frame_rx at 8 clocks per bit.
`timescale 1ns/1ps
module tb_sonar_frame_rx;
    localparam int CPB = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   nvec  = 0;
    int   nfail = 0;

    sonar_frame_rx_if bus ();

    sonar_frame_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Event monitor: pulse counters and cycle stamps for latency checks.
    int cyc = 0, n_valid = 0, n_err = 0, n_both = 0, done_cyc = 0, valid_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.frame_valid) begin n_valid++; valid_cyc = cyc; end
        if (bus.frame_error) n_err++;
        if (bus.frame_valid && bus.frame_error) n_both++;
        if (bus.db_rx_state == 4'd5) done_cyc = cyc;
    end

    task automatic send_bit(input logic b);
        bus.rx_serial = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_char(input logic [6:0] c, input bit bad_stop, input bit bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(c[i]);
        send_bit((^c) ^ bad_par);
        send_bit(!bad_stop);
        bus.rx_serial = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        byte b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            send_char(b[6:0], 1'b0, 1'b0);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.rx_serial = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nvec++; if (bus.angle_bcd !== 12'h000) begin nfail++; $display("FAIL rst_angle got %h want 000", bus.angle_bcd); end
        nvec++; if (bus.distance_bcd !== 16'h0000) begin nfail++; $display("FAIL rst_dist got %h want 0000", bus.distance_bcd); end
        nvec++; if (bus.frame_valid !== 1'b0) begin nfail++; $display("FAIL rst_valid got %b want 0", bus.frame_valid); end
        nvec++; if (bus.frame_error !== 1'b0) begin nfail++; $display("FAIL rst_error got %b want 0", bus.frame_error); end
        nvec++; if (bus.db_rx_state !== 4'd0) begin nfail++; $display("FAIL rst_rxstate got %0d want 0", bus.db_rx_state); end
        nvec++; if (bus.db_parser_state !== 4'd0) begin nfail++; $display("FAIL rst_psstate got %0d want 0", bus.db_parser_state); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_valid_frame();
        int v0 = n_valid, e0 = n_err;
        send_str("045,0123#");
        nvec++; if (n_valid - v0 !== 1) begin nfail++; $display("FAIL t1_valid_cnt got %0d want 1", n_valid - v0); end
        nvec++; if (n_err - e0 !== 0) begin nfail++; $display("FAIL t1_err_cnt got %0d want 0", n_err - e0); end
        nvec++; if (bus.angle_bcd !== 12'h045) begin nfail++; $display("FAIL t1_angle got %h want 045", bus.angle_bcd); end
        nvec++; if (bus.distance_bcd !== 16'h0123) begin nfail++; $display("FAIL t1_dist got %h want 0123", bus.distance_bcd); end
        nvec++; if (valid_cyc - done_cyc !== 1) begin nfail++; $display("FAIL t1_latency got %0d want 1", valid_cyc - done_cyc); end
    endtask

    task automatic test_bad_char();
        int v0, e0;
        send_str("090,0200#");
        nvec++; if (bus.angle_bcd !== 12'h090 || bus.distance_bcd !== 16'h0200) begin nfail++; $display("FAIL t2_first got %h/%h want 090/0200", bus.angle_bcd, bus.distance_bcd); end
        v0 = n_valid; e0 = n_err;
        send_str("09X,0300#");
        nvec++; if (n_err - e0 !== 1) begin nfail++; $display("FAIL t2_err_cnt got %0d want 1", n_err - e0); end
        nvec++; if (n_valid - v0 !== 0) begin nfail++; $display("FAIL t2_valid_cnt got %0d want 0", n_valid - v0); end
        nvec++; if (bus.angle_bcd !== 12'h090 || bus.distance_bcd !== 16'h0200) begin nfail++; $display("FAIL t2_hold got %h/%h want 090/0200", bus.angle_bcd, bus.distance_bcd); end
        v0 = n_valid; e0 = n_err;
        send_str("180,0050#");
        nvec++; if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin nfail++; $display("FAIL t2_third_cnt got v%0d e%0d want v1 e0", n_valid - v0, n_err - e0); end
        nvec++; if (bus.angle_bcd !== 12'h180 || bus.distance_bcd !== 16'h0050) begin nfail++; $display("FAIL t2_third got %h/%h want 180/0050", bus.angle_bcd, bus.distance_bcd); end
    endtask

    task automatic test_glitch();
        int v0 = n_valid, e0 = n_err;
        bus.rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        nvec++; if (bus.db_rx_state !== 4'd1) begin nfail++; $display("FAIL t3_start got %0d want 1", bus.db_rx_state); end
        bus.rx_serial = 1'b1;
        repeat (12) @(negedge clk);
        nvec++; if (bus.db_rx_state !== 4'd0) begin nfail++; $display("FAIL t3_idle got %0d want 0", bus.db_rx_state); end
        nvec++; if (n_valid - v0 !== 0 || n_err - e0 !== 0) begin nfail++; $display("FAIL t3_pulses got v%0d e%0d want v0 e0", n_valid - v0, n_err - e0); end
        nvec++; if (bus.angle_bcd !== 12'h180 || bus.distance_bcd !== 16'h0050) begin nfail++; $display("FAIL t3_hold got %h/%h want 180/0050", bus.angle_bcd, bus.distance_bcd); end
    endtask

    task automatic test_framing();
        int v0 = n_valid, e0 = n_err;
        send_str("1");
        send_char(7'h35, 1'b1, 1'b0);
        nvec++; if (n_err - e0 !== 1) begin nfail++; $display("FAIL t4_err_cnt got %0d want 1", n_err - e0); end
        nvec++; if (bus.db_parser_state !== 4'd4) begin nfail++; $display("FAIL t4_sync got %0d want 4", bus.db_parser_state); end
        send_str("135,0777#");
        nvec++; if (n_valid - v0 !== 0) begin nfail++; $display("FAIL t4_reject got %0d want 0", n_valid - v0); end
        nvec++; if (bus.angle_bcd !== 12'h180 || bus.distance_bcd !== 16'h0050) begin nfail++; $display("FAIL t4_hold got %h/%h want 180/0050", bus.angle_bcd, bus.distance_bcd); end
        send_str("135,0777#");
        nvec++; if (n_valid - v0 !== 1 || n_err - e0 !== 1) begin nfail++; $display("FAIL t4_accept_cnt got v%0d e%0d want v1 e1", n_valid - v0, n_err - e0); end
        nvec++; if (bus.angle_bcd !== 12'h135 || bus.distance_bcd !== 16'h0777) begin nfail++; $display("FAIL t4_accept got %h/%h want 135/0777", bus.angle_bcd, bus.distance_bcd); end
    endtask

    task automatic test_parity();
        int v0 = n_valid, e0 = n_err;
        send_str("12");
        send_char(7'h33, 1'b0, 1'b1);
        send_str(",0456#");
`ifdef SONAR_RX_PARITY_EN
        nvec++; if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin nfail++; $display("FAIL t5_cnt got v%0d e%0d want v0 e1", n_valid - v0, n_err - e0); end
        nvec++; if (bus.angle_bcd !== 12'h135 || bus.distance_bcd !== 16'h0777) begin nfail++; $display("FAIL t5_out got %h/%h want 135/0777", bus.angle_bcd, bus.distance_bcd); end
`else
        nvec++; if (n_err - e0 !== 0 || n_valid - v0 !== 1) begin nfail++; $display("FAIL t5_cnt got v%0d e%0d want v1 e0", n_valid - v0, n_err - e0); end
        nvec++; if (bus.angle_bcd !== 12'h123 || bus.distance_bcd !== 16'h0456) begin nfail++; $display("FAIL t5_out got %h/%h want 123/0456", bus.angle_bcd, bus.distance_bcd); end
`endif
    endtask

    task automatic test_reset_mid();
        send_str("045,01");
        bus.rx_serial = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        nvec++; if (bus.angle_bcd !== 12'h000 || bus.distance_bcd !== 16'h0000) begin nfail++; $display("FAIL t6_clear got %h/%h want 000/0000", bus.angle_bcd, bus.distance_bcd); end
        nvec++; if (bus.db_rx_state !== 4'd0 || bus.db_parser_state !== 4'd0) begin nfail++; $display("FAIL t6_states got %0d/%0d want 0/0", bus.db_rx_state, bus.db_parser_state); end
        bus.rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_str("001,0002#");
        nvec++; if (bus.angle_bcd !== 12'h001 || bus.distance_bcd !== 16'h0002) begin nfail++; $display("FAIL t6_after got %h/%h want 001/0002", bus.angle_bcd, bus.distance_bcd); end
    endtask

    initial begin
        bus.rx_serial = 1'b1;
        test_reset();
        test_valid_frame();
        test_bad_char();
        test_glitch();
        test_framing();
        test_parity();
        test_reset_mid();
        nvec++; if (n_both !== 0) begin nfail++; $display("FAIL exclusive got %0d overlaps want 0", n_both); end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
